// File: rtl/conv_bf16tomxfp_stream.sv
// Streaming BF16 -> MX block converter: collects k BF16 elements arriving lanes per beat,
// derives the shared E8M0 scale and quantises each element through a snapshot and output stage.
module conv_bf16tomxfp_stream #(
    parameter int exp_width = 4,
    parameter int man_width = 3,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int k         = 32,
    parameter int lanes     = 8,
    parameter bit sat       = 1'b0,
    parameter bit e4m3_spec = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [16*lanes-1:0]    i_bf16_vec,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [bit_width*k-1:0] o_mx_vec,
    output logic [7:0]             o_mx_exp
);

    localparam int BEATS    = k / lanes;
    localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BIAS     = (1 << (exp_width - 1)) - 1;
    localparam int EMAX     = (exp_width <= 4) ? (1 << (exp_width - 1)) : 15;
    localparam int CODE_W   = exp_width + man_width;
    localparam bit E4M3_OCP = (exp_width == 4) && e4m3_spec;
    localparam bit HAS_INF  = !E4M3_OCP && (exp_width >= 4);
    // Magnitude codes: largest finite value, and what an overflow encodes to.
    localparam int MAX_CODE = E4M3_OCP ? (1 << CODE_W) - 2 :
                              HAS_INF  ? (((1 << exp_width) - 1) << man_width) - 1 :
                                         (1 << CODE_W) - 1;
    localparam int OVF_CODE = sat      ? MAX_CODE :
                              E4M3_OCP ? (1 << CODE_W) - 1 :
                              HAS_INF  ? (((1 << exp_width) - 1) << man_width) :
                                         MAX_CODE;

    // Quantise one BF16 value against biased shared exponent xs; the code is built as
    // (biased_exp-1)<<man_width + rounded significand, so a rounding carry lands in the exponent.
    function automatic logic [bit_width-1:0] quant_elem(input logic [15:0] x, input logic [7:0] xs);
        int be, rs, sig, kept, rem, half, code;
        be   = int'(x[14:7]) - int'(xs) + BIAS;
        rs   = 7 - man_width + ((be < 1) ? (1 - be) : 0);
        if (rs > 15) rs = 15;
        sig  = int'({1'b1, x[6:0]});
        kept = sig >> rs;
        rem  = sig - (kept << rs);
        half = (rs > 0) ? (1 << (rs - 1)) : 0;
        if ((rs > 0) && ((rem > half) || ((rem == half) && kept[0]))) kept = kept + 1;
        code = ((be < 1) ? 0 : (be - 1)) * (1 << man_width) + kept;
        if (x[14:7] == 8'd0) code = 0;
        else if (code > MAX_CODE) code = OVF_CODE;
        return {x[15], code[CODE_W-1:0]};
    endfunction

    logic                   init_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             max_q, max_d;
    logic                   nan_q, nan_d;
    logic                   full_q, full_d;
    logic [16*k-1:0]        buf_q, buf_d;
    logic                   snap_v_q;
    logic [bit_width*k-1:0] snap_vec_q;
    logic [7:0]             snap_exp_q;
    logic                   out_v_q;
    logic [bit_width*k-1:0] out_vec_q;
    logic [7:0]             out_exp_q;

    logic                   snap_adv, snap_take_ok, accept, completes, handoff;
    logic [7:0]             beat_max, blk_max, blk_x, blk_exp;
    logic                   beat_nan, blk_nan;
    logic [16*k-1:0]        blk_vec;
    logic [bit_width*k-1:0] q_vec;

    // Handshake: a beat moves when i_valid && o_ready, a block leaves when o_valid && i_ready.
    assign snap_adv     = !out_v_q || i_ready;
    assign snap_take_ok = !snap_v_q || snap_adv;
    assign o_ready      = init_q && (!full_q || snap_take_ok);
    assign accept       = i_valid && o_ready;
    assign completes    = i_last || (cnt_q == CW'(BEATS - 1));
    assign handoff      = full_q ? snap_take_ok : (accept && completes && snap_take_ok);

    always_comb begin
        beat_max = '0;
        beat_nan = 1'b0;
        for (int j = 0; j < lanes; j++) begin
            if (i_bf16_vec[j*16+7 +: 8] > beat_max) beat_max = i_bf16_vec[j*16+7 +: 8];
            if (i_bf16_vec[j*16+7 +: 8] == 8'hFF) beat_nan = 1'b1;
        end
    end

    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        max_d  = max_q;
        nan_d  = nan_q;
        full_d = full_q;
        if (handoff && full_q) full_d = 1'b0;
        if (accept) begin
            // First beat of a block clears the buffer so an early i_last leaves zeros behind.
            if (cnt_q == '0) begin
                buf_d = '0;
                max_d = beat_max;
                nan_d = beat_nan;
            end else begin
                max_d = (beat_max > max_q) ? beat_max : max_q;
                nan_d = nan_q | beat_nan;
            end
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CW'(b)) buf_d[b*lanes*16 +: lanes*16] = i_bf16_vec;
            end
            cnt_d = completes ? '0 : cnt_q + 1'b1;
            if (completes && !(handoff && !full_q)) full_d = 1'b1;
        end
    end

    // A completing beat skips the buffer and feeds the snapshot directly.
    always_comb begin
        blk_vec = full_q ? buf_q : buf_d;
        blk_max = full_q ? max_q : max_d;
        blk_nan = full_q ? nan_q : nan_d;
        blk_x   = (blk_max > 8'(EMAX)) ? blk_max - 8'(EMAX) : 8'd0;
        blk_exp = blk_nan ? 8'hFF : blk_x;
        q_vec   = '0;
        for (int i = 0; i < k; i++) begin
            q_vec[i*bit_width +: bit_width] = quant_elem(blk_vec[i*16 +: 16], blk_x);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            init_q     <= 1'b0;
            cnt_q      <= '0;
            max_q      <= '0;
            nan_q      <= 1'b0;
            full_q     <= 1'b0;
            buf_q      <= '0;
            snap_v_q   <= 1'b0;
            snap_vec_q <= '0;
            snap_exp_q <= '0;
            out_v_q    <= 1'b0;
            out_vec_q  <= '0;
            out_exp_q  <= '0;
        end else begin
            init_q <= 1'b1;
            cnt_q  <= cnt_d;
            max_q  <= max_d;
            nan_q  <= nan_d;
            full_q <= full_d;
            buf_q  <= buf_d;
            if (handoff) begin
                snap_v_q   <= 1'b1;
                snap_vec_q <= q_vec;
                snap_exp_q <= blk_exp;
            end else if (snap_adv) begin
                snap_v_q <= 1'b0;
            end
            if (snap_adv) begin
                out_v_q <= snap_v_q;
                if (snap_v_q) begin
                    out_vec_q <= snap_vec_q;
                    out_exp_q <= snap_exp_q;
                end
            end
        end
    end

    assign o_valid  = out_v_q;
    assign o_mx_vec = out_vec_q;
    assign o_mx_exp = out_exp_q;

endmodule

// File: tb/tb_conv_bf16tomxfp_stream.sv
// Bench for conv_bf16tomxfp_stream (E4M3, k=32, lanes=8, sat=0): real-valued reference
// model feeding an expected queue, checked by an independent output monitor.
module tb_conv_bf16tomxfp_stream;

    localparam int K     = 32;
    localparam int LANES = 8;
    localparam int BW    = 8;
    localparam int BEATS = K / LANES;
    localparam bit SAT   = 1'b0;
    localparam int W     = 8 + K * BW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 out_ready = 1'b0;
    logic [16*LANES-1:0]  in_vec = '0;
    logic                 dut_ready, out_valid;
    logic [BW*K-1:0]      mx_vec;
    logic [7:0]           mx_exp;

    int                   checks = 0;
    int                   errors = 0;
    int                   rdy_mode = 0;
    logic [W-1:0]         exp_q[$];
    bit                   nan_q[$];
    logic [15:0]          blk[K];

    conv_bf16tomxfp_stream #(
        .exp_width(4), .man_width(3), .bit_width(BW), .k(K), .lanes(LANES),
        .sat(SAT), .e4m3_spec(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(dut_ready),
        .i_bf16_vec(in_vec), .i_last(in_last), .o_valid(out_valid), .i_ready(out_ready),
        .o_mx_vec(mx_vec), .o_mx_exp(mx_exp)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real e4m3_val(input int c);
        int ef, mf;
        ef = c / 8;
        mf = c % 8;
        if (ef == 0) return (real'(mf) / 8.0) * (2.0 ** (-6.0));
        return (1.0 + real'(mf) / 8.0) * (2.0 ** real'(ef - 7));
    endfunction

    function automatic logic [7:0] ref_elem(input logic [15:0] x, input int xs);
        int  e, ex, code;
        real v, ulp, q, fl, r;
        e = int'(x[14:7]);
        if (e == 0) return {x[15], 7'd0};
        v  = (1.0 + real'(int'(x[6:0])) / 128.0) * (2.0 ** real'(e - xs));
        ex = -6;
        for (int t = 8; t >= -6; t--) begin
            if (v >= 2.0 ** real'(t)) begin
                ex = t;
                break;
            end
        end
        ulp = 2.0 ** real'(ex - 3);
        q   = v / ulp;
        fl  = $floor(q);
        if ((q - fl > 0.5) || ((q - fl == 0.5) && ((int'(fl) % 2) == 1))) fl = fl + 1.0;
        r = fl * ulp;
        if (r > 448.0) code = SAT ? 126 : 127;
        else begin
            code = 0;
            for (int c = 0; c < 127; c++) if (e4m3_val(c) == r) code = c;
        end
        return {x[15], 7'(code)};
    endfunction

    task automatic push_expect();
        int           maxe, xs;
        bit           nan;
        logic [W-1:0] res;
        maxe = 0;
        nan  = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (int'(blk[i][14:7]) > maxe) maxe = int'(blk[i][14:7]);
            if (blk[i][14:7] == 8'hFF) nan = 1'b1;
        end
        xs  = (maxe > 8) ? maxe - 8 : 0;
        res = '0;
        res[W-1 -: 8] = nan ? 8'hFF : 8'(xs);
        for (int i = 0; i < K; i++) res[i*BW +: BW] = ref_elem(blk[i], xs);
        exp_q.push_back(res);
        nan_q.push_back(nan);
    endtask

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_beat(input logic [16*LANES-1:0] d, input logic last);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_vec   = d;
        in_last  = last;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (dut_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic send_block(input int nbeats, input bit last_on_final, input bit push);
        logic [16*LANES-1:0] d;
        for (int i = nbeats * LANES; i < K; i++) blk[i] = 16'h0000;
        for (int b = 0; b < nbeats; b++) begin
            for (int j = 0; j < LANES; j++) d[j*16 +: 16] = blk[b*LANES + j];
            send_beat(d, (b == nbeats - 1) && ((nbeats < BEATS) || last_on_final));
        end
        if (push) push_expect();
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < K; i++) blk[i] = v;
    endtask

    task automatic gen_block();
        int base, e;
        base = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : $urandom_range(60, 200);
        for (int i = 0; i < K; i++) begin
            if ($urandom_range(0, 99) < 6) e = 0;
            else if ($urandom_range(0, 299) == 0) e = 255;
            else begin
                e = base - $urandom_range(0, 18);
                if (e < 1) e = 1;
            end
            blk[i] = {1'($urandom_range(0, 1)), 8'(e), 7'($urandom_range(0, 127))};
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] hold_data;
    bit           hold_pend = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        bit           n;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", W'(out_valid), W'(1));
                chk("hold_data", {mx_exp, mx_vec}, hold_data);
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block actual=%0h required=none", {mx_exp, mx_vec});
                end else begin
                    e = exp_q.pop_front();
                    n = nan_q.pop_front();
                    if (n) chk("blk_nan_scale", W'(mx_exp), W'(e[W-1 -: 8]));
                    else   chk("blk", {mx_exp, mx_vec}, e);
                end
            end else if (out_valid) begin
                hold_pend = 1'b1;
                hold_data = {mx_exp, mx_vec};
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int idx;
        rst_n = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_valid", W'(out_valid), W'(0));
        chk("reset_ready", W'(dut_ready), W'(0));
        chk("reset_exp", W'(mx_exp), W'(0));
        chk("reset_vec", W'(mx_vec), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", W'(dut_ready), W'(1));
        @(posedge clk);
        #1;

        // all 1.0, with two-cycle latency check
        fill(16'h3F80);
        send_block(BEATS, 1'b0, 1'b1);
        @(negedge clk);
        chk("latency_t1", W'(out_valid), W'(0));
        @(negedge clk);
        chk("latency_t2", W'(out_valid), W'(1));
        @(posedge clk);
        #1;

        // one larger element raises the scale
        fill(16'h3F80);
        idx = $urandom_range(0, K - 1);
        blk[idx] = 16'h4040;
        send_block(BEATS, 1'b0, 1'b1);

        // rounding overflow
        fill(16'h3F80);
        blk[$urandom_range(0, K - 1)] = 16'h3FFF;
        send_block(BEATS, 1'b1, 1'b1);

        // NaN forces 0xFF, then an all-zero block
        fill(16'h3F80);
        blk[$urandom_range(0, K - 1)] = 16'h7FC0;
        send_block(BEATS, 1'b0, 1'b1);
        fill(16'h0000);
        send_block(BEATS, 1'b0, 1'b1);

        // early termination after two beats, then a fresh block starting at index 0
        fill(16'h3F80);
        send_block(2, 1'b0, 1'b1);
        fill(16'h4040);
        for (int i = 0; i < LANES; i++) blk[i] = 16'hBF80;
        send_block(BEATS, 1'b0, 1'b1);
        wait_drain();

        // randomised blocks under random downstream stalls
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            gen_block();
            send_block(($urandom_range(0, 3) == 0) ? $urandom_range(1, BEATS - 1) : BEATS,
                       1'($urandom_range(0, 1)), 1'b1);
        end
        rdy_mode = 0;
        wait_drain();

        // sustained backpressure: output + snapshot + collect all fill up
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            gen_block();
            send_block(BEATS, 1'b0, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_low", W'(dut_ready), W'(0));
        end
        @(posedge clk);
        #1 rdy_mode = 0;
        wait_drain();

        // reset with a block in flight and a partial block collected
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        gen_block();
        send_block(BEATS, 1'b0, 1'b0);
        gen_block();
        send_block(2, 1'b1, 1'b0);
        fill(16'h3F80);
        for (int b = 0; b < 2; b++) send_beat({LANES{16'h4040}}, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_ready", W'(dut_ready), W'(0));
        chk("midreset_valid", W'(out_valid), W'(0));
        chk("midreset_exp", W'(mx_exp), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        repeat (8) @(posedge clk);
        #1;
        fill(16'h3F80);
        send_block(BEATS, 1'b0, 1'b1);
        wait_drain();

        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
